// File: rtl/vmem_scroll_ctrl.sv
// Text-VRAM write controller: translates CPU cell writes through a circular row base
// and runs clear-screen / scroll / clear-line fill operations, yielding to the CPU.
module vmem_scroll_ctrl #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_we,
    input  logic [11:0]       cpu_addr,
    input  logic [DATA_W-1:0] cpu_data,
    input  logic              cmd_valid,
    input  logic [1:0]        cmd_op,
    input  logic [4:0]        cmd_arg,
    input  logic [DATA_W-1:0] cmd_fill,
    output logic              vm_we,
    output logic [11:0]       vm_addr,
    output logic [DATA_W-1:0] vm_data,
    output logic [4:0]        row_base,
    output logic              busy,
    output logic              cmd_err
);

    localparam logic [1:0] OP_NOP    = 2'b00;
    localparam logic [1:0] OP_CLEAR  = 2'b01;
    localparam logic [1:0] OP_SCROLL = 2'b10;
    localparam logic [1:0] OP_LINE   = 2'b11;

    localparam logic [4:0] LAST_ROW = 5'd29;
    localparam logic [6:0] LAST_COL = 7'd79;

    typedef enum logic [1:0] {
        IDLE,
        CLEAR,
        LINE
    } state_t;

    state_t              state, state_nx;
    logic [4:0]          row_cnt, row_cnt_nx;
    logic [6:0]          col_cnt, col_cnt_nx;
    logic [4:0]          row_base_nx;
    logic [DATA_W-1:0]   fill, fill_nx;
    logic                engaged;
    logic                accept;
    logic                reject;
    logic                eng_issue;
    logic                eng_last;

    // Logical row to physical row; the 5-bit sum wraps modulo 32 by construction.
    function automatic logic [11:0] xlate(input logic [4:0] lrow, input logic [6:0] col,
                                          input logic [4:0] base);
        logic [4:0] prow;
        prow = lrow + base;
        return {prow, col};
    endfunction

    always_comb begin
        state_nx    = state;
        row_cnt_nx  = row_cnt;
        col_cnt_nx  = col_cnt;
        row_base_nx = row_base;
        fill_nx     = fill;
        accept      = 1'b0;
        reject      = 1'b0;
        eng_issue   = 1'b0;
        eng_last    = 1'b0;

        // busy stays high one cycle past the FSM while the last write is on vm_*
        engaged = (state != IDLE) || busy;

        if (cmd_valid && (cmd_op != OP_NOP)) begin
            if (engaged || ((cmd_op == OP_LINE) && (cmd_arg > LAST_ROW)))
                reject = 1'b1;
            else
                accept = 1'b1;
        end

        if (accept) begin
            fill_nx    = cmd_fill;
            col_cnt_nx = 7'd0;
            case (cmd_op)
                OP_CLEAR: begin
                    row_base_nx = 5'd0;
                    row_cnt_nx  = 5'd0;
                    state_nx    = CLEAR;
                end
                OP_SCROLL: begin
                    row_base_nx = row_base + 5'd1;
                    row_cnt_nx  = LAST_ROW;
                    state_nx    = LINE;
                end
                default: begin
                    row_cnt_nx = cmd_arg;
                    state_nx   = LINE;
                end
            endcase
        end else if ((state != IDLE) && !cpu_we) begin
            eng_issue = 1'b1;
            if (col_cnt == LAST_COL) begin
                col_cnt_nx = 7'd0;
                if ((state == LINE) || (row_cnt == LAST_ROW)) begin
                    eng_last = 1'b1;
                    state_nx = IDLE;
                end else begin
                    row_cnt_nx = row_cnt + 5'd1;
                end
            end else begin
                col_cnt_nx = col_cnt + 7'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            row_cnt  <= 5'd0;
            col_cnt  <= 7'd0;
            row_base <= 5'd0;
            fill     <= '0;
            busy     <= 1'b0;
            cmd_err  <= 1'b0;
        end else begin
            state    <= state_nx;
            row_cnt  <= row_cnt_nx;
            col_cnt  <= col_cnt_nx;
            row_base <= row_base_nx;
            fill     <= fill_nx;
            busy     <= (state_nx != IDLE) || eng_last;
            cmd_err  <= reject;
        end
    end

    // Output write port: CPU cycle wins, the engine stalls in place.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vm_we   <= 1'b0;
            vm_addr <= 12'd0;
            vm_data <= '0;
        end else begin
            vm_we <= cpu_we || eng_issue;
            if (cpu_we) begin
                vm_addr <= xlate(cpu_addr[11:7], cpu_addr[6:0], row_base);
                vm_data <= cpu_data;
            end else begin
                vm_addr <= xlate(row_cnt, col_cnt, row_base);
                vm_data <= fill;
            end
        end
    end

endmodule
